// File: rtl/embed_pkg.sv
// Shared types and sizing for the linear-embedding ReLU stage.
package embed_pkg;

  localparam int EMB_DW   = 8;
  localparam int EMB_ROWS = 15;
  localparam int EMB_COLS = 16;

  typedef logic signed [EMB_DW-1:0] emb_elem_t;
  typedef emb_elem_t [0:EMB_COLS-1] emb_row_t;

  // Sequencer states: waiting for start, collecting rows, presenting frame.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } emb_state_e;

endpackage : embed_pkg

// File: rtl/relu_row.sv
// Combinational ReLU over one embedding row; negative elements become zero.
module relu_row
  import embed_pkg::*;
#(
  parameter int DATA_WIDTH = EMB_DW,
  parameter int NUM_COLS   = EMB_COLS
) (
  input  logic signed [0:NUM_COLS-1][DATA_WIDTH-1:0] row_in,
  output logic signed [0:NUM_COLS-1][DATA_WIDTH-1:0] row_out
);

  // Rectify each element: a set sign bit means negative, so clamp to zero.
  always_comb begin
    row_out = {(NUM_COLS*DATA_WIDTH){1'b0}};
    for (int c = 0; c < NUM_COLS; c++) begin
      if (row_in[c][DATA_WIDTH-1]) begin
        row_out[c] = {DATA_WIDTH{1'b0}};
      end else begin
        row_out[c] = row_in[c];
      end
    end
  end

endmodule : relu_row

// File: rtl/embed_relu_seq.sv
// Row-by-row frame collector: rectifies incoming embedding rows into a
// register buffer and presents the full frame under a valid/ready handshake.
module embed_relu_seq
  import embed_pkg::*;
#(
  parameter int DATA_WIDTH = EMB_DW,
  parameter int NUM_ROWS   = EMB_ROWS,
  parameter int NUM_COLS   = EMB_COLS
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 start,
  input  logic                                                 row_valid,
  output logic                                                 row_ready,
  input  logic signed [0:NUM_COLS-1][DATA_WIDTH-1:0]           row_data,
  output logic        [$clog2(NUM_ROWS)-1:0]                   row_idx,
  output logic                                                 frame_valid,
  input  logic                                                 frame_ready,
  output logic signed [0:NUM_ROWS-1][0:NUM_COLS-1][DATA_WIDTH-1:0] frame_data,
  output logic                                                 busy
);

  localparam int IDX_W = $clog2(NUM_ROWS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS - 1);

  emb_state_e                                           state_r;
  emb_state_e                                           state_s;
  logic [IDX_W-1:0]                                     row_cnt_r;
  logic [IDX_W-1:0]                                     row_cnt_s;
  logic                                                 accept_s;
  logic [NUM_ROWS-1:0]                                  row_we_s;
  logic signed [0:NUM_COLS-1][DATA_WIDTH-1:0]           relu_s;
  logic signed [0:NUM_ROWS-1][0:NUM_COLS-1][DATA_WIDTH-1:0] frame_buf_r;

  // Handshake outputs come straight from the state register, so neither
  // row_valid nor frame_ready can reach row_ready/frame_valid combinationally.
  assign row_ready   = (state_r == FILL);
  assign frame_valid = (state_r == HOLD);
  assign busy        = (state_r != IDLE);
  assign row_idx     = row_cnt_r;
  assign frame_data  = frame_buf_r;
  assign accept_s    = row_valid & row_ready;

  relu_row #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_COLS   (NUM_COLS)
  ) u_relu_row (
    .row_in  (row_data),
    .row_out (relu_s)
  );

  // Next-state and row-counter logic for the IDLE/FILL/HOLD sequencer.
  always_comb begin
    state_s   = state_r;
    row_cnt_s = row_cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = FILL;
          row_cnt_s = {IDX_W{1'b0}};
        end else begin
          state_s   = IDLE;
        end
      end
      FILL: begin
        // start is deliberately ignored here: a frame in progress never restarts.
        if (accept_s) begin
          if (row_cnt_r == LAST_ROW) begin
            state_s   = HOLD;
            row_cnt_s = {IDX_W{1'b0}};
          end else begin
            row_cnt_s = row_cnt_r + IDX_W'(1);
          end
        end else begin
          row_cnt_s = row_cnt_r;
        end
      end
      HOLD: begin
        row_cnt_s = {IDX_W{1'b0}};
        if (frame_ready) begin
          // start in the consume cycle chains straight into the next frame.
          if (start) begin
            state_s = FILL;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s   = IDLE;
        row_cnt_s = {IDX_W{1'b0}};
      end
    endcase
  end

  // One-hot row write enable decoded from the current row counter.
  always_comb begin
    row_we_s = {NUM_ROWS{1'b0}};
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (accept_s && (row_cnt_r == IDX_W'(r))) begin
        row_we_s[r] = 1'b1;
      end else begin
        row_we_s[r] = 1'b0;
      end
    end
  end

  // State and row counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      row_cnt_r <= {IDX_W{1'b0}};
    end else begin
      state_r   <= state_s;
      row_cnt_r <= row_cnt_s;
    end
  end

  // Frame buffer: each row register loads the rectified input only on its accept.
  for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
    // Row register gr, cleared by reset so an aborted frame leaves no data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        frame_buf_r[gr] <= {(NUM_COLS*DATA_WIDTH){1'b0}};
      end else if (row_we_s[gr]) begin
        frame_buf_r[gr] <= relu_s;
      end else begin
        frame_buf_r[gr] <= frame_buf_r[gr];
      end
    end
  end

endmodule : embed_relu_seq

// File: tb/tb_embed_relu_seq.sv
// Scoreboard bench for embed_relu_seq: the driver pushes each expected frame
// into a queue, a monitor pops and compares on every frame handshake.
module tb_embed_relu_seq;

  localparam int DW = 8;
  localparam int NR = 15;
  localparam int NC = 16;

  typedef logic [0:NC-1][DW-1:0]         row_t;
  typedef logic [0:NR-1][0:NC-1][DW-1:0] frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       row_valid = 1'b0;
  logic       frame_ready = 1'b0;
  row_t       row_data = '0;
  logic       row_ready;
  logic       frame_valid;
  logic       busy;
  logic [3:0] row_idx;
  frame_t     frame_data;

  int     n_checks = 0;
  int     n_fail   = 0;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  embed_relu_seq #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string name, input frame_t act, input frame_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int r = 0; r < NR; r++) begin
        for (int c = 0; c < NC; c++) begin
          if (act[r][c] !== exp[r][c]) begin
            $display("FAIL %s: row %0d col %0d got %0d required %0d at %0t",
                     name, r, c, $signed(act[r][c]), $signed(exp[r][c]), $time);
            return;
          end
        end
      end
    end
  endtask

  // Raw signed stimulus value for frame pattern 'kind'.
  function automatic int raw_val(input int kind, input int r, input int c);
    if (kind == 0) return r * 16 + c - 120;
    if (kind == 1 && r == 0 && c < 5) begin
      case (c)
        0:       return -128;
        1:       return -1;
        2:       return 0;
        3:       return 1;
        default: return 127;
      endcase
    end
    return ((r * 53 + c * 29 + kind * 71) % 256) - 128;
  endfunction

  function automatic int relu_ref(input int v);
    return (v > 0) ? v : 0;
  endfunction

  // Drive one frame (or a partial one); pushes the expectation only for full frames.
  task automatic send_frame(input int kind, input int nrows, input int gap_max,
                            input bit do_start, input bit noise, output frame_t expf);
    frame_t rawf;
    int gaps;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        rawf[r][c] = 8'(raw_val(kind, r, c));
        expf[r][c] = 8'(relu_ref(raw_val(kind, r, c)));
      end
    end
    if (nrows == NR) exp_q.push_back(expf);
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_row_ready", 32'(row_ready), 32'd1);
      check("start_row_idx", 32'(row_idx), 32'd0);
    end
    for (int r = 0; r < nrows; r++) begin
      gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gaps) begin
        row_valid = 1'b0;
        row_data  = {$urandom, $urandom, $urandom, $urandom};
        start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
      row_valid = 1'b1;
      row_data  = rawf[r];
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      check("fill_row_idx", 32'(row_idx), 32'(r));
      check("fill_row_ready", 32'(row_ready), 32'd1);
      @(posedge clk); #1;
      row_valid = 1'b0;
      start     = 1'b0;
      n_checks++;
      if (frame_data[r] !== expf[r]) begin
        n_fail++;
        $display("FAIL row_written: row %0d got %h required %h", r, frame_data[r], expf[r]);
      end
    end
    if (nrows == NR) begin
      check("hold_frame_valid", 32'(frame_valid), 32'd1);
      check("hold_row_ready", 32'(row_ready), 32'd0);
      check("hold_row_idx", 32'(row_idx), 32'd0);
    end
  endtask

  // Consume the presented frame after 'stall' cycles; start held during stalls.
  task automatic consume(input int stall, input bit b2b);
    check("consume_valid", 32'(frame_valid), 32'd1);
    repeat (stall) begin
      frame_ready = 1'b0;
      start       = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("stall_still_valid", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    start       = b2b;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    start       = 1'b0;
    check("valid_drop", 32'(frame_valid), 32'd0);
    if (b2b) begin
      check("b2b_row_ready", 32'(row_ready), 32'd1);
      check("b2b_row_idx", 32'(row_idx), 32'd0);
    end else begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_row_ready", 32'(row_ready), 32'd0);
    end
  endtask

  // Monitor: frame scoreboard, accept counting and hold-stability checks.
  int     acc_cnt   = 0;
  bit     hold_prev = 1'b0;
  frame_t prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      if (row_valid && row_ready) acc_cnt++;
      if (frame_valid && hold_prev) check_frame("hold_stable", frame_data, prev_data);
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: frame_valid with empty scoreboard at %0t", $time);
        end else begin
          check_frame("scoreboard_frame", frame_data, exp_q.pop_front());
        end
        check("accepts_per_frame", 32'(acc_cnt), 32'(NR));
        acc_cnt = 0;
      end
      hold_prev = frame_valid && !frame_ready;
      prev_data = frame_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    frame_t zero_f;
    zero_f = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_ready", 32'(row_ready), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_row_idx", 32'(row_idx), 32'd0);
    check_frame("rst_frame_data", frame_data, zero_f);
    rst_n = 1'b1;

    // Idle with garbage on the row interface: nothing may be accepted.
    repeat (10) begin
      row_valid = 1'b1;
      row_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("idle_row_ready_0", 32'(row_ready), 32'd0);
      check("idle_frame_valid_0", 32'(frame_valid), 32'd0);
      check("idle_busy_0", 32'(busy), 32'd0);
    end
    row_valid = 1'b0;
    check_frame("idle_frame_zero", frame_data, zero_f);

    // Ramp frame, no gaps: -120..119
    send_frame(0, NR, 0, 1'b1, 1'b0, f);
    check("ramp_r0c0", 32'(frame_data[0][0]), 32'd0);
    check("ramp_r0c8", 32'(frame_data[0][8]), 32'd0);
    check("ramp_r7c8", 32'(frame_data[7][8]), 32'd0);
    check("ramp_r7c9", 32'(frame_data[7][9]), 32'd1);
    check("ramp_r14c0", 32'(frame_data[14][0]), 32'd104);
    check("ramp_r14c15", 32'(frame_data[14][15]), 32'd119);
    consume(0, 1'b0);

    // Corner values in row 0
    send_frame(1, NR, 0, 1'b1, 1'b0, f);
    check("corner_m128", 32'(frame_data[0][0]), 32'd0);
    check("corner_m1", 32'(frame_data[0][1]), 32'd0);
    check("corner_0", 32'(frame_data[0][2]), 32'd0);
    check("corner_1", 32'(frame_data[0][3]), 32'd1);
    check("corner_127", 32'(frame_data[0][4]), 32'd127);
    consume(3, 1'b0);

    // Random gaps, stalls and start noise during FILL
    for (int k = 2; k < 6; k++) begin
      send_frame(k, NR, 5, 1'b1, 1'b1, f);
      consume($urandom_range(0, 5), 1'b0);
    end

    // Back-to-back frames
    send_frame(6, NR, 0, 1'b1, 1'b0, f);
    consume(2, 1'b1);
    send_frame(7, NR, 2, 1'b0, 1'b0, f);
    consume(0, 1'b0);

    // Reset after 7 rows
    send_frame(8, 7, 1, 1'b1, 1'b0, f);
    rst_n = 1'b0;
    #1;
    check_frame("midrst_frame_zero", frame_data, zero_f);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_row_ready", 32'(row_ready), 32'd0);
    check("midrst_frame_valid", 32'(frame_valid), 32'd0);
    check("midrst_row_idx", 32'(row_idx), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("postrst_frame_valid", 32'(frame_valid), 32'd0);
    end

    // Fresh frame after reset
    send_frame(9, NR, 0, 1'b1, 1'b0, f);
    consume(1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_embed_relu_seq

// File: doc/embed_relu_seq.md
# embed_relu_seq

Sequencer and frame buffer for the linear-embedding ReLU stage. It accepts the 15×16 signed int8 embedding one row (16 elements) per handshake from the embedding matmul. Each accepted row is rectified and stored in a register buffer. The complete frame is then presented to the transformer front-end under a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 8, element width (signed, two's complement)
- NUM_ROWS, 15, rows (tokens) per frame
- NUM_COLS, 16, elements per row (embedding dim)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new frame; sampled only in IDLE or with the frame handshake in HOLD
- row_valid  in  1  upstream row present
- row_ready  out  1  block accepts a row this cycle
- row_data  in  [0:NUM_COLS-1] × DATA_WIDTH signed  one embedding row
- row_idx  out  $clog2(NUM_ROWS)  index of the next row to be accepted
- frame_valid  out  1  full rectified frame available
- frame_ready  in  1  downstream consumes frame
- frame_data  out  [0:NUM_ROWS-1][0:NUM_COLS-1] × DATA_WIDTH signed  buffer contents
- busy  out  1  state ≠ IDLE

## Operation
- FSM states are IDLE, FILL and HOLD.
- IDLE:
  - row_ready=0, frame_valid=0.
  - start=1 → FILL with row_cnt=0.
- FILL:
  - row_ready=1.
  - Accept = row_valid & row_ready. On accept, buf[row_cnt] ← relu(row_data) and row_cnt increments.
  - Accept with row_cnt=NUM_ROWS-1 → HOLD. row_cnt wraps to 0.
  - No accept → state and buffer unchanged; wait states may last any length.
- HOLD:
  - frame_valid=1, row_ready=0.
  - frame_valid & frame_ready → IDLE. If start=1 in the same cycle → FILL directly (back-to-back frames).
  - start without frame_ready is ignored.
- relu(x) per element: x>0 → x, else 0. Examples: -128→0, -1→0, 0→0, 1→1, 127→127.
  - There is no width change: output width = DATA_WIDTH, sign bit always 0 after ReLU.
- The buffer is written only on accept.
- frame_data drives buf continuously. It stays valid and stable in HOLD, and keeps its last frame in IDLE until the next FILL overwrites rows.
- start during FILL is ignored (no restart).
- row_idx = row_cnt. It is 0 in IDLE and HOLD.

## Timing
- Reset values (asynchronous, on rst_n=0):
  - state=IDLE, row_cnt=0, all buf elements 0.
  - row_ready=0, frame_valid=0, busy=0, row_idx=0.
- Outputs are decoded from registered state only. There is no combinational path from row_valid or frame_ready to row_ready or frame_valid.
- start is sampled at cycle t → FILL at t+1, so row_ready=1 from t+1.
- With row_valid held high, rows are accepted at t+1 … t+NUM_ROWS. frame_valid=1 at t+NUM_ROWS+1. Minimum start→frame_valid latency is NUM_ROWS+1 cycles.
- ReLU is combinational between row_data and the buffer write. The rectified row is visible on frame_data the cycle after its accept.
- Frame handshake completes at cycle h → frame_valid=0 at h+1. With start at h, row_ready=1 at h+1 (zero bubble).
- Reset mid-FILL or mid-HOLD:
  - The partial or complete frame is discarded and the buffer is cleared.
  - No frame_valid pulse is produced after reset.
- row_data is ignored whenever row_ready=0.

## Structure
- Package embed_pkg holds:
  - localparams EMB_DW=8, EMB_ROWS=15, EMB_COLS=16.
  - Typedef emb_elem_t (logic signed [EMB_DW-1:0]).
  - Typedef emb_row_t (emb_elem_t [0:EMB_COLS-1]).
  - Enum emb_state_e {IDLE, FILL, HOLD}.
- Sub-module relu_row: combinational ReLU over one NUM_COLS-element row. It is instantiated once, between row_data and the buffer write port.
- Top level contains the FSM, row counter, and a NUM_ROWS×NUM_COLS register buffer with a one-row write enable decoded from row_cnt.

## Test plan
- Reset then idle 10 cycles: all outputs 0, frame_data all 0. Pulse start: row_ready=1 next cycle, row_idx=0.
- Stream 15 rows, row r element c = (r*16+c)-120 wrapped to int8, row_valid always high: frame_valid at start+16. Each element = max(value,0), e.g. row 0 col 0 (-120)→0, row 14 col 15 (119)→119.
- Corner values -128, -1, 0, 1, 127 in one row → stored as 0, 0, 0, 1, 127.
- Random row_valid gaps and frame_ready stalls of 0–5 cycles:
  - Exactly 15 accepts per frame.
  - frame_data stable while frame_valid=1 and frame_ready=0.
  - start during FILL has no effect.
- Back-to-back frames: start asserted in the frame_ready cycle → row_ready=1 next cycle. Second frame overwrites the buffer row by row and matches the scoreboard.
- Assert rst_n=0 after 7 rows: buffer zero, state IDLE, frame_valid never asserted. A fresh 15-row frame afterwards is correct.
